// File: rtl/pipe_pkg.sv
// Shared types for the fetch/decode pipeline: stage states, default NOP word and payload.
package pipe_pkg;

    localparam int unsigned FD_DATA_W = 16;
    localparam int unsigned FD_PC_W   = 16;

    localparam logic [FD_DATA_W-1:0] NOP_DEFAULT = 16'h0000;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_e;

    typedef struct packed {
        logic [FD_PC_W-1:0]   pc;
        logic [FD_DATA_W-1:0] instr;
    } fd_payload_t;

    // Occupancy implied by a stage state.
    function automatic logic [1:0] state_count(stage_state_e s);
        case (s)
            ST_BUSY: state_count = 2'd1;
            ST_FULL: state_count = 2'd2;
            default: state_count = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/fetch_decode_skid_stage.sv
// Fetch-to-decode stage with a two-entry skid buffer, registered handshake outputs and flush.
module fetch_decode_skid_stage
    import pipe_pkg::*;
#(
    parameter int unsigned        DATA_W         = 16,
    parameter int unsigned        PC_W           = 16,
    parameter logic [DATA_W-1:0]  NOP_WORD       = DATA_W'(NOP_DEFAULT),
    parameter int unsigned        FLUSH_PC_CLEAR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count
);

    stage_state_e      state_q, state_d;
    logic [PC_W-1:0]   main_pc_q, main_pc_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [PC_W-1:0]   skid_pc_q, skid_pc_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [1:0]        count_q;
    logic              in_fire;
    logic              out_fire;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_pc    = main_pc_q;
    assign out_data  = main_data_q;
    assign count     = count_q;

    // Next-state and entry updates; flush overrides the handshake.
    always_comb begin
        state_d     = state_q;
        main_pc_d   = main_pc_q;
        main_data_d = main_data_q;
        skid_pc_d   = skid_pc_q;
        skid_data_d = skid_data_q;

        if (flush) begin
            state_d     = ST_EMPTY;
            skid_pc_d   = '0;
            skid_data_d = '0;
            main_data_d = NOP_WORD;
            if (FLUSH_PC_CLEAR != 0) begin
                main_pc_d = '0;
            end
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_pc_d   = in_pc;
                        main_data_d = in_data;
                        state_d     = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (in_fire && out_fire) begin
                        main_pc_d   = in_pc;
                        main_data_d = in_data;
                    end else if (in_fire) begin
                        skid_pc_d   = in_pc;
                        skid_data_d = in_data;
                        state_d     = ST_FULL;
                    end else if (out_fire) begin
                        main_data_d = NOP_WORD;
                        state_d     = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        main_pc_d   = skid_pc_q;
                        main_data_d = skid_data_q;
                        skid_pc_d   = '0;
                        skid_data_d = '0;
                        state_d     = ST_BUSY;
                    end
                end
                default: begin
                    state_d     = ST_EMPTY;
                    main_data_d = NOP_WORD;
                end
            endcase
        end
    end

    // Handshake outputs are registered from the next state so no input reaches them combinationally.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            main_pc_q   <= '0;
            main_data_q <= NOP_WORD;
            skid_pc_q   <= '0;
            skid_data_q <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            state_q     <= state_d;
            main_pc_q   <= main_pc_d;
            main_data_q <= main_data_d;
            skid_pc_q   <= skid_pc_d;
            skid_data_q <= skid_data_d;
            in_ready_q  <= (state_d != ST_FULL);
            out_valid_q <= (state_d != ST_EMPTY);
            count_q     <= state_count(state_d);
        end
    end

endmodule

// File: tb/tb_fetch_decode_skid_stage.sv
// Scoreboard bench for fetch_decode_skid_stage: directed vectors plus a short random run.
module tb_fetch_decode_skid_stage;
    import pipe_pkg::*;

    localparam int unsigned FLUSH_PC_CLEAR = 0;
    localparam logic [15:0] NOP = 16'h0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_pc = '0;
    logic [15:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_pc;
    logic [15:0] out_data;
    logic [1:0]  count;

    int n_vec  = 0;
    int n_fail = 0;

    fd_payload_t exp_q[$];
    logic [15:0] last_pc = '0;
    logic        prev_rst = 1'b1;

    fetch_decode_skid_stage #(
        .DATA_W(16), .PC_W(16), .NOP_WORD(NOP), .FLUSH_PC_CLEAR(FLUSH_PC_CLEAR)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_data(out_data),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: at every falling edge compare outputs against the reference queue.
    initial begin
        forever begin
            @(negedge clk);
            if (prev_rst) begin
                chk("rst_in_ready", 32'(in_ready), 32'(0));
                chk("rst_out_valid", 32'(out_valid), 32'(0));
                chk("rst_count", 32'(count), 32'(0));
                chk("rst_out_pc", 32'(out_pc), 32'(0));
                chk("rst_out_data", 32'(out_data), 32'(NOP));
            end else begin
                chk("count", 32'(count), 32'(exp_q.size()));
                chk("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
                if (exp_q.size() > 0) begin
                    chk("out_valid", 32'(out_valid), 32'(1));
                    chk("out_pc", 32'(out_pc), 32'(exp_q[0].pc));
                    chk("out_data", 32'(out_data), 32'(exp_q[0].instr));
                    last_pc = exp_q[0].pc;
                end else begin
                    chk("idle_out_valid", 32'(out_valid), 32'(0));
                    chk("idle_out_data", 32'(out_data), 32'(NOP));
                    chk("idle_out_pc", 32'(out_pc), 32'(last_pc));
                end
            end
            if (reset) begin
                exp_q.delete();
                last_pc = '0;
            end else begin
                if (!prev_rst && exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
                if (flush) begin
                    exp_q.delete();
                    if (FLUSH_PC_CLEAR != 0) last_pc = '0;
                end
            end
            prev_rst = reset;
        end
    end

    // Present one pair until accepted; expected entry is queued on the accepting edge.
    task automatic send(input logic [15:0] pc, input logic [15:0] data);
        logic hs;
        logic done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_pc    = pc;
        in_data  = data;
        for (int t = 0; t < 64 && !done; t++) begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk);
            if (hs) begin
                exp_q.push_back('{pc: pc, instr: data});
                done = 1'b1;
            end
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            n_vec++;
            n_fail++;
            $display("FAIL send_timeout: pc %0h never accepted, required acceptance within 64 cycles", pc);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic hs;
        // Reset, then release; in_ready rises one cycle after release.
        cycles(3);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready_low", 32'(in_ready), 32'(0));
        @(negedge clk);
        chk("post_rst_in_ready_high", 32'(in_ready), 32'(1));
        cycles(1);

        // Streaming with out_ready high.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(16'(2 * i), 16'hA000 + 16'(i));
        cycles(3);
        chk("stream_last_pc", 32'(out_pc), 32'h0006);

        // Back-pressure: two absorbed, third held until out_ready rises.
        out_ready = 1'b0;
        fork
            begin
                send(16'h0030, 16'h4444);
                send(16'h0032, 16'h5555);
                send(16'h0034, 16'h6666);
            end
            begin
                repeat (4) @(negedge clk);
                chk("bp_count_full", 32'(count), 32'(2));
                chk("bp_in_ready_low", 32'(in_ready), 32'(0));
                chk("bp_head_pc", 32'(out_pc), 32'h0030);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        cycles(4);
        chk("bp_drained_pc", 32'(out_pc), 32'h0034);

        // Flush while FULL with a discarded input.
        out_ready = 1'b0;
        send(16'h0010, 16'h1111);
        send(16'h0012, 16'h2222);
        in_valid = 1'b1;
        in_pc    = 16'h0014;
        in_data  = 16'hBEEF;
        flush    = 1'b1;
        cycles(1);
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 32'(out_valid), 32'(0));
        chk("flush_out_data", 32'(out_data), 32'(NOP));
        chk("flush_count", 32'(count), 32'(0));
        chk("flush_in_ready", 32'(in_ready), 32'(1));
        chk("flush_out_pc", 32'(out_pc), (FLUSH_PC_CLEAR != 0) ? 32'(0) : 32'h0010);
        cycles(2);

        // Flush coinciding with out_fire in BUSY.
        out_ready = 1'b1;
        send(16'h0020, 16'h3333);
        flush = 1'b1;
        cycles(1);
        flush = 1'b0;
        @(negedge clk);
        chk("flush_fire_count", 32'(count), 32'(0));
        chk("flush_fire_data", 32'(out_data), 32'(NOP));
        chk("flush_fire_pc", 32'(out_pc), (FLUSH_PC_CLEAR != 0) ? 32'(0) : 32'h0020);
        cycles(1);

        // Reset while FULL, out_ready toggling.
        out_ready = 1'b0;
        send(16'h0040, 16'h7777);
        send(16'h0042, 16'h8888);
        reset = 1'b1;
        flush = 1'b1;
        cycles(1);
        flush = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("mid_rst_out_valid", 32'(out_valid), 32'(0));
        chk("mid_rst_out_pc", 32'(out_pc), 32'(0));
        chk("mid_rst_out_data", 32'(out_data), 32'(NOP));
        chk("mid_rst_count", 32'(count), 32'(0));
        chk("mid_rst_in_ready", 32'(in_ready), 32'(0));
        cycles(1);
        out_ready = 1'b0;
        cycles(1);
        reset = 1'b0;
        @(negedge clk);
        chk("rel_in_ready_low", 32'(in_ready), 32'(0));
        @(negedge clk);
        chk("rel_in_ready_high", 32'(in_ready), 32'(1));
        cycles(1);

        // Random handshake traffic with occasional flush.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_pc     = 16'($urandom);
            in_data   = 16'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 31) == 0);
            @(negedge clk);
            hs = in_valid && in_ready && !flush;
            @(posedge clk);
            if (hs) exp_q.push_back('{pc: in_pc, instr: in_data});
            #1;
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        cycles(4);
        @(negedge clk);
        chk("final_count", 32'(count), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
